n2tl_aqsm_mt: RTL and testbench

//   Multi-outstanding Acquire/Grant/GrantAck tracker between TL Logic and OXmgr TX/RX.

---
 rtl/n2tl_aq_pkg.sv | 19 +
 rtl/n2tl_rr_arb.sv | 28 ++
 rtl/n2tl_aqsm_mt.sv | 151 +++++++++++++++
 tb/tb_n2tl_aqsm_mt.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/n2tl_aq_pkg.sv
// Shared types and defaults for the multi-outstanding Acquire/Grant/GrantAck tracker.
package n2tl_aq_pkg;

    typedef enum logic [3:0] {
        SLOT_IDLE        = 4'b0001,
        SLOT_ACQ_GEN     = 4'b0010,
        SLOT_GNT_WAIT    = 4'b0100,
        SLOT_GNTACK_PEND = 4'b1000
    } slot_state_e;

    localparam int DEF_SINK_W      = 26;
    localparam int DEF_TIMEOUT_CYC = 4096;

    // Counter only has to reach cyc-1; keep at least one bit so TIMEOUT_CYC of 0..2 still elaborates.
    function automatic int cnt_width(input int cyc);
        return (cyc > 2) ? $clog2(cyc) : 1;
    endfunction

endpackage

// File: rtl/n2tl_rr_arb.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo N (N is a power of two).
module n2tl_rr_arb #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          vld,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;

    // Scan from the farthest offset down so the nearest request to ptr wins.
    always_comb begin
        vld  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = ptr + IW'(k);
            if (req[cand]) begin
                vld = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/n2tl_aqsm_mt.sv
// Tracks NUM_SLOTS outstanding Acquires (source id = slot index) from allocation through
// Acquire generation, Grant match, GrantAck generation, or timeout abort.
module n2tl_aqsm_mt
    import n2tl_aq_pkg::*;
#(
    parameter int NUM_SLOTS   = 4,
    parameter int SINK_W      = DEF_SINK_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int SRC_W       = $clog2(NUM_SLOTS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 acq_req_valid,
    output logic                 acq_req_ready,
    output logic [SRC_W-1:0]     acq_req_src,
    output logic                 acq_gen_en,
    output logic [SRC_W-1:0]     acq_gen_src,
    input  logic                 acq_gen_done,
    input  logic                 gnt_valid,
    input  logic [SRC_W-1:0]     gnt_source,
    input  logic [SINK_W-1:0]    gnt_sink,
    output logic                 gnt_ack,
    output logic                 gnt_spurious,
    output logic                 gntack_gen_en,
    output logic [SINK_W-1:0]    gntack_e_sink,
    input  logic                 gntack_gen_done,
    output logic [NUM_SLOTS-1:0] slot_busy,
    output logic                 timeout_err,
    output logic [SRC_W-1:0]     timeout_src
);

    localparam int CNT_W = cnt_width(TIMEOUT_CYC);

    slot_state_e [NUM_SLOTS-1:0]             st_q, st_d;
    logic        [NUM_SLOTS-1:0][CNT_W-1:0]  cnt_q;
    logic        [NUM_SLOTS-1:0][SINK_W-1:0] sink_q;

    logic [NUM_SLOTS-1:0] is_idle, is_acq, is_wait, is_pend, gnt_mine, expire;
    logic [SRC_W-1:0]     alloc_src, to_idx, acq_ptr, gack_ptr, gntack_src;
    logic [SRC_W-1:0]     acq_pick, gack_pick;
    logic                 acq_any, gack_any, alloc_fire, acq_fin, gack_fin, gnt_hit;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        assign is_idle[g]  = (st_q[g] == SLOT_IDLE);
        assign is_acq[g]   = (st_q[g] == SLOT_ACQ_GEN);
        assign is_wait[g]  = (st_q[g] == SLOT_GNT_WAIT);
        assign is_pend[g]  = (st_q[g] == SLOT_GNTACK_PEND);
        assign gnt_mine[g] = gnt_hit && (gnt_source == SRC_W'(g));
        // A Grant landing in the expiry cycle takes priority over the abort.
        assign expire[g]   = (TIMEOUT_CYC != 0) && is_wait[g] && !gnt_mine[g] &&
                             (cnt_q[g] == CNT_W'(TIMEOUT_CYC - 1));
    end

    assign slot_busy     = ~is_idle;
    assign acq_req_ready = |is_idle;
    assign acq_req_src   = alloc_src;
    assign alloc_fire    = acq_req_valid && acq_req_ready;
    assign acq_fin       = acq_gen_en && acq_gen_done;
    assign gack_fin      = gntack_gen_en && gntack_gen_done;
    assign gnt_hit       = gnt_valid && is_wait[gnt_source];

    always_comb begin
        alloc_src = '0;
        to_idx    = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (is_idle[i]) alloc_src = SRC_W'(i);
            if (expire[i])  to_idx    = SRC_W'(i);
        end
    end

    n2tl_rr_arb #(.N(NUM_SLOTS), .IW(SRC_W)) u_acq_arb (
        .req (is_acq),
        .ptr (acq_ptr),
        .vld (acq_any),
        .idx (acq_pick)
    );

    n2tl_rr_arb #(.N(NUM_SLOTS), .IW(SRC_W)) u_gack_arb (
        .req (is_pend),
        .ptr (gack_ptr),
        .vld (gack_any),
        .idx (gack_pick)
    );

    always_comb begin
        st_d = st_q;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            case (st_q[i])
                SLOT_IDLE:
                    if (alloc_fire && alloc_src == SRC_W'(i)) st_d[i] = SLOT_ACQ_GEN;
                SLOT_ACQ_GEN:
                    if (acq_fin && acq_gen_src == SRC_W'(i)) st_d[i] = SLOT_GNT_WAIT;
                SLOT_GNT_WAIT:
                    if (gnt_mine[i])    st_d[i] = SLOT_GNTACK_PEND;
                    else if (expire[i]) st_d[i] = SLOT_IDLE;
                SLOT_GNTACK_PEND:
                    if (gack_fin && gntack_src == SRC_W'(i)) st_d[i] = SLOT_IDLE;
                default:
                    st_d[i] = SLOT_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) st_q[i] <= SLOT_IDLE;
            cnt_q         <= '0;
            sink_q        <= '0;
            acq_gen_en    <= 1'b0;
            acq_gen_src   <= '0;
            acq_ptr       <= '0;
            gntack_gen_en <= 1'b0;
            gntack_src    <= '0;
            gntack_e_sink <= '0;
            gack_ptr      <= '0;
            gnt_ack       <= 1'b0;
            gnt_spurious  <= 1'b0;
            timeout_err   <= 1'b0;
            timeout_src   <= '0;
        end else begin
            st_q <= st_d;
            // Held at zero outside GNT_WAIT, so it starts from zero on entry.
            for (int i = 0; i < NUM_SLOTS; i++)
                cnt_q[i] <= is_wait[i] ? cnt_q[i] + CNT_W'(1) : '0;
            if (gnt_hit) sink_q[gnt_source] <= gnt_sink;

            gnt_ack      <= gnt_hit;
            gnt_spurious <= gnt_valid && !is_wait[gnt_source];
            timeout_err  <= |expire;
            timeout_src  <= to_idx;

            if (acq_gen_en) begin
                if (acq_gen_done) acq_gen_en <= 1'b0;
            end else if (acq_any) begin
                acq_gen_en  <= 1'b1;
                acq_gen_src <= acq_pick;
                acq_ptr     <= acq_pick + SRC_W'(1);
            end

            if (gntack_gen_en) begin
                if (gntack_gen_done) gntack_gen_en <= 1'b0;
            end else if (gack_any) begin
                gntack_gen_en <= 1'b1;
                gntack_src    <= gack_pick;
                gntack_e_sink <= sink_q[gack_pick];
                gack_ptr      <= gack_pick + SRC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_n2tl_aqsm_mt.sv
// Bench for n2tl_aqsm_mt: directed flows plus randomized traffic against a transaction-level model.
module tb_n2tl_aqsm_mt;

    localparam int NS = 4;
    localparam int SW = 2;
    localparam int KW = 26;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          acq_req_valid, acq_req_ready, acq_gen_en, acq_gen_done;
    logic [SW-1:0] acq_req_src, acq_gen_src, gnt_source, timeout_src;
    logic          gnt_valid, gnt_ack, gnt_spurious, gntack_gen_en, gntack_gen_done, timeout_err;
    logic [KW-1:0] gnt_sink, gntack_e_sink;
    logic [NS-1:0] slot_busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    n2tl_aqsm_mt #(.NUM_SLOTS(NS), .SINK_W(KW), .TIMEOUT_CYC(TO)) dut (
        .clk             (clk),
        .reset           (reset),
        .acq_req_valid   (acq_req_valid),
        .acq_req_ready   (acq_req_ready),
        .acq_req_src     (acq_req_src),
        .acq_gen_en      (acq_gen_en),
        .acq_gen_src     (acq_gen_src),
        .acq_gen_done    (acq_gen_done),
        .gnt_valid       (gnt_valid),
        .gnt_source      (gnt_source),
        .gnt_sink        (gnt_sink),
        .gnt_ack         (gnt_ack),
        .gnt_spurious    (gnt_spurious),
        .gntack_gen_en   (gntack_gen_en),
        .gntack_e_sink   (gntack_e_sink),
        .gntack_gen_done (gntack_gen_done),
        .slot_busy       (slot_busy),
        .timeout_err     (timeout_err),
        .timeout_src     (timeout_src)
    );

    // Reference model: slot phase 0=free 1=acquire owed 2=awaiting grant 3=grantack owed.
    int            m_ph[NS];
    int            m_age[NS];
    logic [KW-1:0] m_sink[NS];
    bit            m_aen, m_gen, m_ack, m_spur, m_to;
    int            m_asrc, m_aptr, m_gsrc, m_gptr, m_tosrc;
    logic [KW-1:0] m_esink;

    function automatic int rr_pick(int ptr, int phase);
        for (int k = 0; k < NS; k++)
            if (m_ph[(ptr + k) % NS] == phase) return (ptr + k) % NS;
        return -1;
    endfunction

    function automatic void model_update(bit r, bit v, bit ad, bit gv, int gs, logic [KW-1:0] gk, bit kd);
        int nph[NS];
        int p;
        m_ack = 0; m_spur = 0; m_to = 0;
        if (r) begin
            for (int i = 0; i < NS; i++) begin m_ph[i] = 0; m_age[i] = 0; m_sink[i] = '0; end
            m_aen = 0; m_gen = 0; m_asrc = 0; m_aptr = 0; m_gsrc = 0; m_gptr = 0;
            m_esink = '0; m_tosrc = 0;
            return;
        end
        nph = m_ph;
        p = rr_pick(0, 0);
        if (v && p >= 0) nph[p] = 1;
        if (m_aen) begin
            if (ad) begin m_aen = 0; nph[m_asrc] = 2; m_age[m_asrc] = 0; end
        end else begin
            p = rr_pick(m_aptr, 1);
            if (p >= 0) begin m_aen = 1; m_asrc = p; m_aptr = (p + 1) % NS; end
        end
        for (int i = 0; i < NS; i++) begin
            if (m_ph[i] == 2) begin
                if (gv && gs == i) begin nph[i] = 3; m_sink[i] = gk; m_ack = 1; end
                else if (m_age[i] == TO - 1) begin
                    nph[i] = 0;
                    if (!m_to) m_tosrc = i;
                    m_to = 1;
                end else m_age[i]++;
            end
        end
        if (gv && m_ph[gs] != 2) m_spur = 1;
        if (m_gen) begin
            if (kd) begin m_gen = 0; nph[m_gsrc] = 0; end
        end else begin
            p = rr_pick(m_gptr, 3);
            if (p >= 0) begin m_gen = 1; m_gsrc = p; m_gptr = (p + 1) % NS; m_esink = m_sink[p]; end
        end
        m_ph = nph;
    endfunction

    task automatic compare_model();
        int            free_src = rr_pick(0, 0);
        logic [NS-1:0] busy = '0;
        bit            bad;
        for (int i = 0; i < NS; i++) busy[i] = (m_ph[i] != 0);
        bad = (acq_req_ready !== (free_src >= 0)) ||
              (free_src >= 0 && acq_req_src !== SW'(free_src)) ||
              (acq_gen_en !== m_aen) || (m_aen && acq_gen_src !== SW'(m_asrc)) ||
              (gnt_ack !== m_ack) || (gnt_spurious !== m_spur) ||
              (gntack_gen_en !== m_gen) || (m_gen && gntack_e_sink !== m_esink) ||
              (slot_busy !== busy) || (timeout_err !== m_to) ||
              (m_to && timeout_src !== SW'(m_tosrc));
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL model t=%0t actual rdy=%b src=%0d aen=%b asrc=%0d ack=%b spur=%b ken=%b esink=%h busy=%b to=%b tosrc=%0d required rdy=%b src=%0d aen=%b asrc=%0d ack=%b spur=%b ken=%b esink=%h busy=%b to=%b tosrc=%0d",
                     $time, acq_req_ready, acq_req_src, acq_gen_en, acq_gen_src, gnt_ack, gnt_spurious,
                     gntack_gen_en, gntack_e_sink, slot_busy, timeout_err, timeout_src,
                     free_src >= 0, free_src, m_aen, m_asrc, m_ack, m_spur, m_gen, m_esink, busy, m_to, m_tosrc);
        end
    endtask

    task automatic tick();
        bit            r  = reset;
        bit            v  = acq_req_valid;
        bit            ad = acq_gen_done;
        bit            gv = gnt_valid;
        bit            kd = gntack_gen_done;
        int            gs = int'(gnt_source);
        logic [KW-1:0] gk = gnt_sink;
        @(posedge clk);
        #1;
        model_update(r, v, ad, gv, gs, gk, kd);
        compare_model();
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle_in();
        acq_req_valid = 0; acq_gen_done = 0; gnt_valid = 0;
        gnt_source = '0; gnt_sink = '0; gntack_gen_done = 0;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1; tick(); tick(); reset = 0;
    endtask

    // Allocate all slots and emit their Acquires as soon as each is offered.
    task automatic fill_all();
        int allocs = 0, dones = 0;
        for (int c = 0; c < 40 && dones < NS; c++) begin
            acq_req_valid = (allocs < NS);
            if (acq_req_valid && acq_req_ready) allocs++;
            acq_gen_done = acq_gen_en;
            if (acq_gen_en) dones++;
            tick();
        end
        idle_in();
        chk("fill acquires done", 64'(dones), 64'(NS));
    endtask

    typedef struct {
        bit            v, ad, gv, kd;
        logic [SW-1:0] gs;
        logic [KW-1:0] gk;
        bit            rdy, aen, ack, ken;
        logic [SW-1:0] asrc;
        logic [KW-1:0] es;
        logic [NS-1:0] busy;
    } vec_t;

    function automatic vec_t mk(int v, int ad, int gv, int gs, int gk, int kd,
                                int rdy, int aen, int asrc, int ack, int ken, int es, int busy);
        vec_t t;
        t.v = (v != 0); t.ad = (ad != 0); t.gv = (gv != 0); t.kd = (kd != 0);
        t.gs = SW'(gs); t.gk = KW'(gk);
        t.rdy = (rdy != 0); t.aen = (aen != 0); t.ack = (ack != 0); t.ken = (ken != 0);
        t.asrc = SW'(asrc); t.es = KW'(es); t.busy = NS'(busy);
        return t;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          tbl[8];
        logic [63:0]   act, exp;
        int            ord[4];
        logic [KW-1:0] sk;
        int            w, allocs, dones;
        bit            granted, seen_full, realloc, early;

        // Reset state
        do_reset();
        chk("rst slot_busy", 64'(slot_busy), 64'(0));
        chk("rst acq_gen_en", 64'(acq_gen_en), 64'(0));
        chk("rst gntack_gen_en", 64'(gntack_gen_en), 64'(0));
        chk("rst gnt_ack", 64'(gnt_ack), 64'(0));
        chk("rst timeout_err", 64'(timeout_err), 64'(0));
        chk("rst acq_req_ready", 64'(acq_req_ready), 64'(1));
        chk("rst acq_req_src", 64'(acq_req_src), 64'(0));

        // Single flow: req, done three cycles later, grant, GrantAck
        tbl[0] = mk(1,0,0,0,0,0,       1,0,0,0,0,0,1);
        tbl[1] = mk(0,0,0,0,0,0,       1,1,0,0,0,0,1);
        tbl[2] = mk(0,0,0,0,0,0,       1,1,0,0,0,0,1);
        tbl[3] = mk(0,1,0,0,0,0,       1,0,0,0,0,0,1);
        tbl[4] = mk(0,0,1,0,'h3A5,0,   1,0,0,1,0,0,1);
        tbl[5] = mk(0,0,0,0,0,0,       1,0,0,0,1,'h3A5,1);
        tbl[6] = mk(0,0,0,0,0,1,       1,0,0,0,0,0,0);
        tbl[7] = mk(0,0,0,0,0,0,       1,0,0,0,0,0,0);
        for (int i = 0; i < 8; i++) begin
            acq_req_valid = tbl[i].v; acq_gen_done = tbl[i].ad; gnt_valid = tbl[i].gv;
            gnt_source = tbl[i].gs; gnt_sink = tbl[i].gk; gntack_gen_done = tbl[i].kd;
            tick();
            act = {28'd0, acq_req_ready, acq_gen_en, acq_gen_en ? acq_gen_src : 2'd0, gnt_ack,
                   gntack_gen_en, gntack_gen_en ? gntack_e_sink : 26'd0, slot_busy};
            exp = {28'd0, tbl[i].rdy, tbl[i].aen, tbl[i].asrc, tbl[i].ack,
                   tbl[i].ken, tbl[i].es, tbl[i].busy};
            chk($sformatf("flow row%0d", i), act, exp);
        end
        idle_in();

        // Full: fifth request waits until slot 2 retires, then lands in slot 2
        do_reset();
        dones = 0; granted = 0; seen_full = 0; realloc = 0;
        acq_req_valid = 1;
        for (int c = 0; c < 60 && !realloc; c++) begin
            gnt_valid = 0;
            if (dones == 3 && !granted) begin
                gnt_valid = 1; gnt_source = 2'd2; gnt_sink = 26'h2BEEF; granted = 1;
            end
            acq_gen_done = acq_gen_en;
            if (acq_gen_en) dones++;
            gntack_gen_done = gntack_gen_en;
            if (!acq_req_ready) seen_full = 1;
            if (acq_req_ready && seen_full) begin
                chk("full realloc src", 64'(acq_req_src), 64'(2));
                realloc = 1;
            end
            tick();
        end
        idle_in();
        chk("full ready dropped", 64'(seen_full), 64'(1));
        chk("full realloc seen", 64'(realloc), 64'(1));
        chk("full slot2 reused", 64'(slot_busy[2]), 64'(1));

        // Out-of-order grants 3,1,0,2
        do_reset();
        fill_all();
        ord = '{3, 1, 0, 2};
        for (int k = 0; k < 4; k++) begin
            sk = KW'(32'h100 + ord[k] * 17);
            gnt_valid = 1; gnt_source = SW'(ord[k]); gnt_sink = sk;
            tick();
            gnt_valid = 0;
            chk($sformatf("ooo gnt_ack src%0d", ord[k]), 64'(gnt_ack), 64'(1));
            w = 0;
            while (!gntack_gen_en && w < 4) begin tick(); w++; end
            chk($sformatf("ooo gntack_en src%0d", ord[k]), 64'(gntack_gen_en), 64'(1));
            chk($sformatf("ooo e_sink src%0d", ord[k]), 64'(gntack_e_sink), 64'(sk));
            gntack_gen_done = 1;
            tick();
            gntack_gen_done = 0;
            chk($sformatf("ooo freed src%0d", ord[k]), 64'(slot_busy[ord[k]]), 64'(0));
        end

        // Spurious grant to an idle slot
        do_reset();
        gnt_valid = 1; gnt_source = 2'd1; gnt_sink = 26'h55;
        tick();
        idle_in();
        chk("spur pulse", 64'(gnt_spurious), 64'(1));
        chk("spur no ack", 64'(gnt_ack), 64'(0));
        chk("spur busy", 64'(slot_busy), 64'(0));
        tick();
        chk("spur one cycle", 64'(gnt_spurious), 64'(0));

        // Timeout with no grant, then a grant in the expiry cycle
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            acq_req_valid = 1; tick(); acq_req_valid = 0;
            tick();
            chk("to acq_gen_en", 64'(acq_gen_en), 64'(1));
            acq_gen_done = 1; tick(); acq_gen_done = 0;
            early = 0;
            for (int t = 1; t <= 15; t++) begin
                tick();
                if (timeout_err) early = 1;
            end
            chk($sformatf("to early pass%0d", pass), 64'(early), 64'(0));
            if (pass == 0) begin
                tick();
                chk("to err at clk16", 64'(timeout_err), 64'(1));
                chk("to src", 64'(timeout_src), 64'(0));
                tick();
                chk("to err one cycle", 64'(timeout_err), 64'(0));
                chk("to slot freed", 64'(slot_busy), 64'(0));
            end else begin
                gnt_valid = 1; gnt_source = 2'd0; gnt_sink = 26'h1234;
                tick();
                gnt_valid = 0;
                chk("late gnt ack", 64'(gnt_ack), 64'(1));
                chk("late gnt no err", 64'(timeout_err), 64'(0));
                tick();
                chk("late gnt no err next", 64'(timeout_err), 64'(0));
                chk("late gnt gntack_en", 64'(gntack_gen_en), 64'(1));
                gntack_gen_done = 1; tick(); gntack_gen_done = 0;
            end
        end

        // Reset while one slot waits for its grant and another is being acquired
        do_reset();
        acq_req_valid = 1; tick(); tick(); acq_req_valid = 0;
        acq_gen_done = 1; tick(); acq_gen_done = 0;
        tick();
        chk("mid acq_gen_en", 64'(acq_gen_en), 64'(1));
        chk("mid busy", 64'(slot_busy), 64'(3));
        reset = 1; acq_gen_done = 1; gnt_valid = 1; gnt_source = 2'd0; gntack_gen_done = 1;
        tick();
        act = {31'd0, acq_gen_en, acq_gen_src, gnt_ack, gnt_spurious, gntack_gen_en,
               gntack_e_sink, timeout_err, timeout_src};
        chk("mid rst regs zero", act, 64'(0));
        chk("mid rst busy", 64'(slot_busy), 64'(0));
        reset = 0; idle_in();
        tick();

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset           = ($urandom_range(0, 199) == 0);
            acq_req_valid   = ($urandom_range(0, 1) == 1);
            acq_gen_done    = ($urandom_range(0, 1) == 1);
            gnt_valid       = ($urandom_range(0, 3) == 0);
            gnt_source      = SW'($urandom_range(0, NS - 1));
            gnt_sink        = KW'($urandom);
            gntack_gen_done = ($urandom_range(0, 1) == 1);
            tick();
        end
        reset = 0; idle_in();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
